// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture block.
// Holds the capture FSM state encoding, default image geometry and the
// RGB565 -> RGB332 pixel conversion used when a byte pair is complete.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    LINE_B1,
    LINE_B2
  } cam_state_e;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int AW_DEF    = 15;

  // Keeps the top three red bits, the top three green bits (which sit in the
  // low bits of the high byte) and the top two blue bits of the low byte.
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    logic unused_bits;
    unused_bits = ^{hi[4:3], lo[7:5], lo[2:0]};
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer for the camera pins plus pixel-clock rising-edge detector.
// pclk, href, vsync and the data byte travel through one shared flop chain so
// that all eleven bits arrive in the system domain on the same cycle.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pclk_in,
  input  logic       href_in,
  input  logic       vsync_in,
  input  logic [7:0] data_in,
  output logic       href_o,
  output logic       vsync_o,
  output logic [7:0] data_o,
  output logic       pclk_rise
);

  logic [10:0] sync_q [SYNC_STAGES];
  logic [10:0] sync_d [SYNC_STAGES];
  logic        pclk_prev_q;
  logic        pclk_prev_d;

  // Shift the packed camera bits one stage per clk and remember last pclk.
  always_comb begin
    sync_d[0] = {pclk_in, href_in, vsync_in, data_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    pclk_prev_d = sync_q[SYNC_STAGES-1][10];
  end

  // Synchronizer chain and edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      pclk_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      pclk_prev_q <= pclk_prev_d;
    end
  end

  assign pclk_rise = sync_q[SYNC_STAGES-1][10] & ~pclk_prev_q;
  assign href_o    = sync_q[SYNC_STAGES-1][9];
  assign vsync_o   = sync_q[SYNC_STAGES-1][8];
  assign data_o    = sync_q[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/cam_capture.sv
// Camera capture: turns the OV7670-style byte stream into RGB332 frame-buffer
// writes in raster order. Camera pins are sampled as data in the clk domain.
// Optional feature macro: CAM_ERR_EN adds the sticky err_line output that
// flags malformed lines and frames cut short by an early vsync.
module cam_capture #(
  parameter int AW          = 15,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_en,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          frame_done
`ifdef CAM_ERR_EN
  ,
  output logic          err_line
`endif
);

  import cam_pkg::*;

  localparam int PW = $clog2(IMG_W + 1);
  localparam int LW = $clog2(IMG_H + 1);
  localparam logic [PW-1:0] PX_MAX   = PW'(IMG_W);
  localparam logic [LW-1:0] LN_LAST  = LW'(IMG_H - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

  logic       s_href;
  logic       s_vsync;
  logic [7:0] s_data;
  logic       pclk_rise;

  cam_state_e    state_q, state_d;
  logic [PW-1:0] px_cnt_q, px_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [7:0]    hi_q, hi_d;
  logic          byte_seen_q, byte_seen_d;
  logic          vsync_prev_q, vsync_prev_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          frame_done_q, frame_done_d;
`ifdef CAM_ERR_EN
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
`endif

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .pclk_in  (CAM_pclk),
    .href_in  (CAM_href),
    .vsync_in (CAM_vsync),
    .data_in  (CAM_px_data),
    .href_o   (s_href),
    .vsync_o  (s_vsync),
    .data_o   (s_data),
    .pclk_rise(pclk_rise)
  );

  // Next-state and datapath: everything advances only on a pixel-clock rise.
  // line_base tracks line_cnt*IMG_W so the address needs just one adder.
  always_comb begin
    state_d      = state_q;
    px_cnt_d     = px_cnt_q;
    line_cnt_d   = line_cnt_q;
    line_base_d  = line_base_q;
    hi_d         = hi_q;
    byte_seen_d  = byte_seen_q;
    vsync_prev_d = vsync_prev_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    frame_done_d = 1'b0;
`ifdef CAM_ERR_EN
    err_d        = err_q;
    ovf_d        = ovf_q;
`endif
    if (pclk_rise) begin
      vsync_prev_d = s_vsync;
      case (state_q)
        IDLE: begin
          if (s_vsync) state_d = WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (vsync_prev_q && !s_vsync && capture_en) state_d = LINE_B1;
        end
        LINE_B1, LINE_B2: begin
          if (s_vsync) begin
            state_d = WAIT_FRAME;
`ifdef CAM_ERR_EN
            err_d = 1'b1;
`endif
          end else if (s_href) begin
            byte_seen_d = 1'b1;
            if (state_q == LINE_B1) begin
              hi_d    = s_data;
              state_d = LINE_B2;
`ifdef CAM_ERR_EN
              if (px_cnt_q == PX_MAX) ovf_d = 1'b1;
`endif
            end else begin
              state_d = LINE_B1;
              if (px_cnt_q != PX_MAX) begin
                mem_we_d   = 1'b1;
                mem_addr_d = line_base_q + AW'(px_cnt_q);
                mem_data_d = rgb565_to_rgb332(hi_q, s_data);
                px_cnt_d   = px_cnt_q + 1'b1;
              end
            end
          end else begin
            state_d = LINE_B1;
            if (byte_seen_q) begin
`ifdef CAM_ERR_EN
              if (state_q == LINE_B2 || px_cnt_q != PX_MAX || ovf_q) err_d = 1'b1;
              ovf_d = 1'b0;
`endif
              byte_seen_d = 1'b0;
              px_cnt_d    = '0;
              if (line_cnt_q == LN_LAST) begin
                state_d      = WAIT_FRAME;
                frame_done_d = 1'b1;
              end else begin
                line_cnt_d  = line_cnt_q + 1'b1;
                line_base_d = line_base_q + ROW_STEP;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d == WAIT_FRAME) begin
        px_cnt_d    = '0;
        line_cnt_d  = '0;
        line_base_d = '0;
        byte_seen_d = 1'b0;
`ifdef CAM_ERR_EN
        ovf_d       = 1'b0;
`endif
      end
    end
  end

  // State, counters and registered frame-buffer outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      px_cnt_q     <= '0;
      line_cnt_q   <= '0;
      line_base_q  <= '0;
      hi_q         <= '0;
      byte_seen_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CAM_ERR_EN
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      px_cnt_q     <= px_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_base_q  <= line_base_d;
      hi_q         <= hi_d;
      byte_seen_q  <= byte_seen_d;
      vsync_prev_q <= vsync_prev_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      frame_done_q <= frame_done_d;
`ifdef CAM_ERR_EN
      err_q        <= err_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign frame_done = frame_done_q;
`ifdef CAM_ERR_EN
  assign err_line   = err_q;
`endif

endmodule
